// File: rtl/wb_arbiter_pkg.sv
// Shared widths and helpers for the writeback arbiter and its deferral buffer.
// REG_SIZE/REG_ADDR and WB_MUL_LAT are also used by the M1..M5 multiply pipe.
package wb_arbiter_pkg;

   localparam int REG_SIZE   = 32;
   localparam int REG_ADDR   = 5;
   localparam int WB_MUL_LAT = 5;

   typedef struct packed {
      logic                we;
      logic [REG_ADDR-1:0] wreg;
      logic [REG_SIZE-1:0] wdata;
   } wb_req_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular deferral buffer for displaced ALU results: per-entry valid bit,
// saturating age counter and a parallel register-compare squash.
module wb_fifo
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int AGE_W   = 3,
   parameter int SQ_AGE  = 4,
   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W  = cnt_width(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                push,
   input  logic [REG_ADDR-1:0] push_wreg,
   input  logic [REG_SIZE-1:0] push_wdata,
   input  logic                pop,
   input  logic                squash_en,
   input  logic [REG_ADDR-1:0] squash_wreg,
   output logic                head_valid,
   output logic [REG_ADDR-1:0] head_wreg,
   output logic [REG_SIZE-1:0] head_wdata,
   output logic [CNT_W-1:0]    count
);

   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ent_vld   [DEPTH];
   logic [REG_ADDR-1:0] ent_wreg  [DEPTH];
   logic [REG_SIZE-1:0] ent_wdata [DEPTH];

   function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      head_d  = pop  ? wrap_inc(head_q) : head_q;
      tail_d  = push ? wrap_inc(tail_q) : tail_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic                occ_q, occ_d, vld_q, vld_d;
      logic [AGE_W-1:0]    age_q, age_d;
      logic [REG_ADDR-1:0] wreg_q, wreg_d;
      logic [REG_SIZE-1:0] wdata_q, wdata_d;

      always_comb begin
         occ_d   = occ_q;
         vld_d   = vld_q;
         age_d   = age_q;
         wreg_d  = wreg_q;
         wdata_d = wdata_q;
         if (occ_q) begin
            if (age_q != AGE_MAX)
               age_d = age_q + AGE_W'(1);
            if (squash_en && vld_q && (wreg_q == squash_wreg) && (int'(age_q) > SQ_AGE))
               vld_d = 1'b0;
         end
         if (pop && (head_q == PTR_W'(gi))) begin
            occ_d = 1'b0;
            vld_d = 1'b0;
            age_d = '0;
         end
         // The completion cycle itself counts, so a fresh entry is already age 1.
         if (push && (tail_q == PTR_W'(gi))) begin
            occ_d   = 1'b1;
            vld_d   = 1'b1;
            age_d   = AGE_W'(1);
            wreg_d  = push_wreg;
            wdata_d = push_wdata;
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            occ_q   <= 1'b0;
            vld_q   <= 1'b0;
            age_q   <= '0;
            wreg_q  <= '0;
            wdata_q <= '0;
         end else begin
            occ_q   <= occ_d;
            vld_q   <= vld_d;
            age_q   <= age_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
         end
      end

      assign ent_vld[gi]   = vld_q;
      assign ent_wreg[gi]  = wreg_q;
      assign ent_wdata[gi] = wdata_q;
   end

   assign head_valid = ent_vld[head_q];
   assign head_wreg  = ent_wreg[head_q];
   assign head_wdata = ent_wdata[head_q];
   assign count      = count_q;

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: multiply always wins, displaced ALU results are deferred.
// Optional macro WB_R0_FILTER_EN suppresses all writes to r0.
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int DEPTH   = 2,
   parameter int MUL_LAT = WB_MUL_LAT,
   parameter int ALU_LAT = 1,
   parameter int AGE_W   = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                alu_valid,
   input  logic [REG_ADDR-1:0] alu_wreg,
   input  logic [REG_SIZE-1:0] alu_wdata,
   input  logic                mul_valid,
   input  logic [REG_ADDR-1:0] mul_wreg,
   input  logic [REG_SIZE-1:0] mul_wdata,
   output logic                regwrite,
   output logic [REG_ADDR-1:0] wreg,
   output logic [REG_SIZE-1:0] wdata,
   output logic                alu_stall,
   output logic                err_overflow
);

   localparam int CNT_W = cnt_width(DEPTH);

   logic                regwrite_q, regwrite_d;
   logic [REG_ADDR-1:0] wreg_q, wreg_d;
   logic [REG_SIZE-1:0] wdata_q, wdata_d;
   logic                err_q, err_d;

   wb_req_t             sel;
   logic                pop, push, bypass, alu_keep, want_push, full;
   logic                head_valid;
   logic [REG_ADDR-1:0] head_wreg;
   logic [REG_SIZE-1:0] head_wdata;
   logic [CNT_W-1:0]    count;

   wb_fifo #(
      .DEPTH  (DEPTH),
      .AGE_W  (AGE_W),
      .SQ_AGE (MUL_LAT - ALU_LAT)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .push_wreg   (alu_wreg),
      .push_wdata  (alu_wdata),
      .pop         (pop),
      .squash_en   (mul_valid),
      .squash_wreg (mul_wreg),
      .head_valid  (head_valid),
      .head_wreg   (head_wreg),
      .head_wdata  (head_wdata),
      .count       (count)
   );

   always_comb begin
      sel.we    = 1'b0;
      sel.wreg  = alu_wreg;
      sel.wdata = alu_wdata;
      pop       = 1'b0;
      bypass    = 1'b0;
      if (mul_valid) begin
         sel.we    = 1'b1;
         sel.wreg  = mul_wreg;
         sel.wdata = mul_wdata;
      end else if (count != '0) begin
         pop       = 1'b1;
         sel.we    = head_valid;
         sel.wreg  = head_wreg;
         sel.wdata = head_wdata;
      end else if (alu_valid) begin
         sel.we = 1'b1;
         bypass = 1'b1;
      end
`ifdef WB_R0_FILTER_EN
      if (sel.wreg == '0)
         sel.we = 1'b0;
      alu_keep = alu_valid && (alu_wreg != '0);
`else
      alu_keep = alu_valid;
`endif
      full      = (count == CNT_W'(DEPTH));
      want_push = alu_keep && !bypass;
      // A full buffer can still accept if its head drains in the same cycle.
      push      = want_push && !(full && !pop);

      regwrite_d = sel.we;
      wreg_d     = sel.we ? sel.wreg  : wreg_q;
      wdata_d    = sel.we ? sel.wdata : wdata_q;
      err_d      = err_q || (want_push && full && !pop);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         regwrite_q <= 1'b0;
         wreg_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         regwrite_q <= regwrite_d;
         wreg_q     <= wreg_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
      end
   end

   assign regwrite     = regwrite_q;
   assign wreg         = wreg_q;
   assign wdata        = wdata_q;
   assign err_overflow = err_q;
   assign alu_stall    = (count >= CNT_W'(DEPTH - 1));

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue model.
// Honours WB_R0_FILTER_EN when the design is built with it.
module tb_wb_arbiter;
   import wb_arbiter_pkg::*;

   localparam int DEPTH   = 2;
   localparam int MUL_LAT = 5;
   localparam int ALU_LAT = 1;
   localparam int AGE_W   = 3;
   localparam int AGE_MAX = (1 << AGE_W) - 1;

   logic                clk = 1'b0;
   logic                reset = 1'b1;
   logic                alu_valid = 1'b0;
   logic [REG_ADDR-1:0] alu_wreg = '0;
   logic [REG_SIZE-1:0] alu_wdata = '0;
   logic                mul_valid = 1'b0;
   logic [REG_ADDR-1:0] mul_wreg = '0;
   logic [REG_SIZE-1:0] mul_wdata = '0;
   logic                regwrite;
   logic [REG_ADDR-1:0] wreg;
   logic [REG_SIZE-1:0] wdata;
   logic                alu_stall;
   logic                err_overflow;

   int checks   = 0;
   int failures = 0;

   wb_arbiter #(
      .DEPTH   (DEPTH),
      .MUL_LAT (MUL_LAT),
      .ALU_LAT (ALU_LAT),
      .AGE_W   (AGE_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .alu_valid    (alu_valid),
      .alu_wreg     (alu_wreg),
      .alu_wdata    (alu_wdata),
      .mul_valid    (mul_valid),
      .mul_wreg     (mul_wreg),
      .mul_wdata    (mul_wdata),
      .regwrite     (regwrite),
      .wreg         (wreg),
      .wdata        (wdata),
      .alu_stall    (alu_stall),
      .err_overflow (err_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: buffered ALU results in arrival order, each stamped with its completion cycle.
   typedef struct {
      logic [REG_ADDR-1:0] r;
      logic [REG_SIZE-1:0] d;
      bit                  v;
      int                  t;
   } ent_t;

   ent_t                mq[$];
   int                  cyc = 0;
   bit                  exp_we = 0;
   bit                  exp_err = 0;
   logic [REG_ADDR-1:0] exp_reg = '0;
   logic [REG_SIZE-1:0] exp_dat = '0;

   function automatic int age_of(input int t);
      int a;
      a = cyc - t;
      return (a > AGE_MAX) ? AGE_MAX : a;
   endfunction

   always @(negedge clk) begin
      bit                  nwe, bypass, keep;
      logic [REG_ADDR-1:0] nr;
      logic [REG_SIZE-1:0] nd;
      ent_t                e;
      if (reset) begin
         mq.delete();
         exp_we  = 0;
         exp_err = 0;
         exp_reg = '0;
         exp_dat = '0;
         check("rst_regwrite", regwrite, 0);
         check("rst_wreg", wreg, 0);
         check("rst_wdata", wdata, 0);
         check("rst_stall", alu_stall, 0);
         check("rst_err", err_overflow, 0);
      end else begin
         check("regwrite", regwrite, exp_we);
         if (exp_we) begin
            check("wreg", wreg, exp_reg);
            check("wdata", wdata, exp_dat);
         end
         check("stall", alu_stall, (mq.size() >= DEPTH - 1));
         check("err", err_overflow, exp_err);

         nwe = 0; bypass = 0; nr = '0; nd = '0;
         if (mul_valid) begin
            nwe = 1; nr = mul_wreg; nd = mul_wdata;
            foreach (mq[i])
               if (mq[i].v && mq[i].r == mul_wreg && age_of(mq[i].t) > MUL_LAT - ALU_LAT)
                  mq[i].v = 0;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            nwe = e.v; nr = e.r; nd = e.d;
         end else if (alu_valid) begin
            nwe = 1; nr = alu_wreg; nd = alu_wdata; bypass = 1;
         end
         keep = alu_valid;
`ifdef WB_R0_FILTER_EN
         if (nr == '0) nwe = 0;
         keep = alu_valid && (alu_wreg != '0);
`endif
         if (keep && !bypass) begin
            if (mq.size() < DEPTH) begin
               e.r = alu_wreg; e.d = alu_wdata; e.v = 1; e.t = cyc;
               mq.push_back(e);
            end else begin
               exp_err = 1;
            end
         end
         exp_we = nwe;
         if (nwe) begin
            exp_reg = nr;
            exp_dat = nd;
         end
         cyc++;
      end
   end

   task automatic step(input logic av, input logic [REG_ADDR-1:0] ar, input logic [REG_SIZE-1:0] ad,
                       input logic mv, input logic [REG_ADDR-1:0] mr, input logic [REG_SIZE-1:0] md);
      alu_valid = av; alu_wreg = ar; alu_wdata = ad;
      mul_valid = mv; mul_wreg = mr; mul_wdata = md;
      $display("txn t=%0t alu=%0b r%0d=0x%0h mul=%0b r%0d=0x%0h", $time, av, ar, ad, mv, mr, md);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic pulse_reset();
      alu_valid = 1'b0; mul_valid = 1'b0;
      reset = 1'b1;
      #1;
      check("async_rst_regwrite", regwrite, 0);
      check("async_rst_stall", alu_stall, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check("lit_reset_regwrite", regwrite, 0);
      check("lit_reset_err", err_overflow, 0);

      // Idle bypass.
      step(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
      check("lit_bypass_we", regwrite, 1);
      check("lit_bypass_wreg", wreg, 3);
      check("lit_bypass_wdata", wdata, 32'h11);
      check("lit_bypass_stall", alu_stall, 0);
      idle();

      // Collision: multiply first, ALU next cycle.
      step(1'b1, 5'd6, 32'hBB, 1'b1, 5'd5, 32'hAA);
      check("lit_coll_mul", {regwrite, 3'b0, wreg, wdata[7:0]}, {1'b1, 3'b0, 5'd5, 8'hAA});
      check("lit_coll_stall", alu_stall, 1);
      idle();
      check("lit_coll_alu", {regwrite, 3'b0, wreg, wdata[7:0]}, {1'b1, 3'b0, 5'd6, 8'hBB});
      check("lit_coll_unstall", alu_stall, 0);
      idle();

      // Younger multiply to r7 at age 5 squashes the buffered ALU value.
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'd1, 32'h100);
      for (int i = 1; i <= 4; i++) step(1'b0, '0, '0, 1'b1, 5'(i), 32'h200 + i);
      step(1'b0, '0, '0, 1'b1, 5'd7, 32'h9);
      check("lit_sq_mul_wdata", wdata, 32'h9);
      idle();
      check("lit_sq_popped_we", regwrite, 0);
      check("lit_sq_wdata_held", wdata, 32'h9);
      idle();

      // Older multiply to r7 at age 3: both land, multiply first.
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'd1, 32'h100);
      step(1'b0, '0, '0, 1'b1, 5'd2, 32'h300);
      step(1'b0, '0, '0, 1'b1, 5'd3, 32'h301);
      step(1'b0, '0, '0, 1'b1, 5'd7, 32'h9);
      check("lit_keep_mul", {wreg, wdata[7:0]}, {5'd7, 8'h9});
      idle();
      check("lit_keep_alu", {regwrite, 3'b0, wreg, wdata[7:0]}, {1'b1, 3'b0, 5'd7, 8'h1});
      idle();

      // Reset with two entries buffered, just as draining would begin.
      step(1'b1, 5'd8, 32'h21, 1'b1, 5'd1, 32'h400);
      step(1'b1, 5'd9, 32'h22, 1'b1, 5'd2, 32'h401);
      pulse_reset();
      for (int i = 0; i < 3; i++) begin
         idle();
         check("lit_post_rst_we", regwrite, 0);
      end

      // Overflow: full buffer, multiply holding the port, extra ALU result.
      step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd1, 32'h500);
      step(1'b1, 5'd11, 32'hA1, 1'b1, 5'd2, 32'h501);
      step(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h502);
      check("lit_ovf_err", err_overflow, 1);
      step(1'b0, '0, '0, 1'b1, 5'd1, 32'h503);
      idle();
      check("lit_ovf_drain0", {wreg, wdata[7:0]}, {5'd10, 8'hA0});
      idle();
      check("lit_ovf_drain1", {wreg, wdata[7:0]}, {5'd11, 8'hA1});
      idle();
      check("lit_ovf_no_r4", regwrite, 0);
      check("lit_ovf_sticky", err_overflow, 1);
      pulse_reset();

      // Random traffic, mostly honouring alu_stall, with small register range to force collisions.
      for (int n = 0; n < 1500; n++) begin
         logic av, mv;
         if ($urandom_range(0, 299) == 0) begin
            pulse_reset();
         end else begin
            av = ($urandom_range(0, 3) != 0) && (!alu_stall || ($urandom_range(0, 19) == 0));
            mv = ($urandom_range(0, 9) < 4);
            step(av, 5'($urandom_range(0, 3)), $urandom,
                 mv, 5'($urandom_range(0, 3)), $urandom);
         end
      end
      repeat (4) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
